// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed common-ground 7-segment driver: scans NUM_DIGITS hex digits with
// double-buffered load, decimal points, leading-zero blanking, per-digit blink and frame strobe.
module sevenseg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 65536,
    parameter int BLINK_FRAMES   = 64,
    parameter bit GND_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] datain,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    output logic [NUM_DIGITS-1:0]   grounds,
    output logic [6:0]              display,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [NUM_DIGITS-1:0] GND_IDLE = {NUM_DIGITS{GND_ACTIVE_LOW}};

    logic [DW-1:0]           div_cnt;
    logic [IW-1:0]           idx, idx_nxt;
    logic [4*NUM_DIGITS-1:0] act_data, act_data_nxt, pend_data;
    logic [NUM_DIGITS-1:0]   act_dp, act_dp_nxt, pend_dp;
    logic                    pend_valid;
    logic [BW-1:0]           blink_cnt;
    logic                    blink_ph, blink_ph_nxt;
    logic                    slot_end, frame_end;

    logic [NUM_DIGITS-1:0]   lz_blank, onehot, gnd_nxt;
    logic                    lz_run, sel_blank, dp_nxt;
    logic [3:0]              nib, sel_nib;
    logic [6:0]              disp_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0: seg = 7'b1111110;
            4'h1: seg = 7'b0110000;
            4'h2: seg = 7'b1101101;
            4'h3: seg = 7'b1111001;
            4'h4: seg = 7'b0110011;
            4'h5: seg = 7'b1011011;
            4'h6: seg = 7'b1011111;
            4'h7: seg = 7'b1110000;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1111011;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b0011111;
            4'hC: seg = 7'b1001110;
            4'hD: seg = 7'b0111101;
            4'hE: seg = 7'b1001111;
            default: seg = 7'b1000111;
        endcase
        return seg;
    endfunction

    // Active data only changes on the frame boundary; a load on that very edge bypasses pending.
    always_comb begin
        slot_end     = (div_cnt == DIV_LAST);
        frame_end    = slot_end && (idx == IDX_LAST);
        idx_nxt      = idx;
        if (slot_end)
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        act_data_nxt = act_data;
        act_dp_nxt   = act_dp;
        if (frame_end && load) begin
            act_data_nxt = datain;
            act_dp_nxt   = dp_in;
        end else if (frame_end && pend_valid) begin
            act_data_nxt = pend_data;
            act_dp_nxt   = pend_dp;
        end
        blink_ph_nxt = blink_ph;
        if (frame_end && (blink_cnt == BLINK_LAST))
            blink_ph_nxt = ~blink_ph;
    end

    // Leading-zero run stops at the first nonzero digit or the first set decimal point.
    always_comb begin
        lz_run   = blank_lz;
        lz_blank = '0;
        nib      = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            nib         = act_data_nxt[4*(NUM_DIGITS-k)-1 -: 4];
            lz_run      = lz_run && (nib == 4'h0) && !act_dp_nxt[k];
            lz_blank[k] = lz_run && (k < NUM_DIGITS - 1);
        end
        sel_nib   = act_data_nxt[4*(NUM_DIGITS-int'(idx_nxt))-1 -: 4];
        sel_blank = lz_blank[idx_nxt] || (blink_ph_nxt && blink_en[idx_nxt]);
        disp_nxt  = sel_blank ? 7'b0 : hex7(sel_nib);
        dp_nxt    = !sel_blank && act_dp_nxt[idx_nxt];
        onehot    = '0;
        onehot[idx_nxt] = 1'b1;
        gnd_nxt   = GND_ACTIVE_LOW ? ~onehot : onehot;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            idx        <= '0;
            act_data   <= '0;
            act_dp     <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
            blink_cnt  <= '0;
            blink_ph   <= 1'b0;
            grounds    <= GND_IDLE;
            display    <= '0;
            dp         <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            div_cnt    <= slot_end ? '0 : div_cnt + DW'(1);
            idx        <= idx_nxt;
            act_data   <= act_data_nxt;
            act_dp     <= act_dp_nxt;
            if (load) begin
                pend_data <= datain;
                pend_dp   <= dp_in;
            end
            pend_valid <= (load || pend_valid) && !frame_end;
            if (frame_end)
                blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + BW'(1);
            blink_ph   <= blink_ph_nxt;
            grounds    <= gnd_nxt;
            display    <= disp_nxt;
            dp         <= dp_nxt;
            frame_done <= frame_end;
        end
    end

endmodule
